// File: rtl/key_pkg.sv
// Shared types and helpers for the KEY step-control front end.
// Optional feature macro used by key_debounce_ch: KEY_AUTO_REPEAT_EN.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHK,
      PRESSED,
      REL_CHK
   } key_state_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser chain, debounce FSM and optional auto-repeat.
// Build option: define KEY_AUTO_REPEAT_EN to emit extra key_press pulses while held.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RELEASED  | key accepted as up, waiting for a low sample
// PRESS_CHK | key seen low, counting stable low samples before accepting
// PRESSED   | key accepted as down (auto-repeat timing runs here)
// REL_CHK   | key seen high, counting stable high samples before accepting
module key_debounce_ch #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release
);
   import key_pkg::*;

   localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Repeat timing must be at least one cycle or the compare values underflow.
   if (REPEAT_DELAY < 1) begin : g_chk_rd
      $error("key_debounce_ch: REPEAT_DELAY must be >= 1");
   end
   if (REPEAT_PERIOD < 1) begin : g_chk_rp
      $error("key_debounce_ch: REPEAT_PERIOD must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   key_state_t             state;
   logic [CW-1:0]          cnt;

   assign s = sync[SYNC_STAGES-1];

`ifdef KEY_AUTO_REPEAT_EN
   localparam int            RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW        = cnt_w(RPT_MAX);
   localparam logic [RW-1:0] RPT_DLAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_PLAST = RW'(REPEAT_PERIOD - 1);

   // rpt_first selects the initial delay until the first repeat pulse fires.
   logic [RW-1:0] rpt;
   logic          rpt_first;
   logic          rpt_hit;

   assign rpt_hit = (rpt == (rpt_first ? RPT_DLAST : RPT_PLAST));
`endif

   // Synchroniser chain; idles high so a released key looks released after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], key_n};
      end
   end

   // Debounce FSM with registered level and one-cycle pulse outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RELEASED;
         cnt         <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
         rpt         <= '0;
         rpt_first   <= 1'b1;
`endif
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         case (state)
            RELEASED: begin
               if (!s) begin
                  state <= PRESS_CHK;
                  cnt   <= '0;
               end
            end
            PRESS_CHK: begin
               if (s) begin
                  state <= RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state     <= PRESSED;
                  key_level <= 1'b1;
                  key_press <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                  rpt       <= '0;
                  rpt_first <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (s) begin
                  state <= REL_CHK;
                  cnt   <= '0;
               end
`ifdef KEY_AUTO_REPEAT_EN
               else if (rpt_hit) begin
                  key_press <= 1'b1;
                  rpt       <= '0;
                  rpt_first <= 1'b0;
               end else begin
                  rpt <= rpt + 1'b1;
               end
`endif
            end
            REL_CHK: begin
               // rpt is left untouched here so a bounce back resumes the repeat timing.
               if (!s) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state       <= RELEASED;
                  key_level   <= 1'b0;
                  key_release <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
                  rpt         <= '0;
                  rpt_first   <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: rtl/key_step_ctrl.sv
// KEY push-button front end: NKEYS independent debounced channels.
// Build option: KEY_AUTO_REPEAT_EN enables auto-repeat press pulses in every channel.
module key_step_ctrl #(
   parameter int NKEYS           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NKEYS-1:0] key_n,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release
);
   import key_pkg::*;

   if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
      $error("key_step_ctrl: DEBOUNCE_CYCLES must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_chk_ss
      $error("key_step_ctrl: SYNC_STAGES must be >= 2");
   end

   // One self-contained channel per key.
   for (genvar i = 0; i < NKEYS; i++) begin : g_ch
      key_debounce_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .key_n      (key_n[i]),
         .key_level  (key_level[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i])
      );
   end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl (NKEYS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// With KEY_AUTO_REPEAT_EN defined it runs the auto-repeat scenario instead of the default set.
module tb_key_step_ctrl;

   localparam int NK = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;

   typedef struct packed {
      int            c;
      logic [NK-1:0] p;
      logic [NK-1:0] r;
      logic [NK-1:0] l;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   ev_t e;
   ev_t o;
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   key_step_ctrl #(
      .NKEYS          (NK),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every cycle carrying a pulse, stamped with the number of edges seen so far.
   always @(negedge clk) begin
      if ((key_press | key_release) != '0)
         obs_q.push_back('{cyc, key_press, key_release, key_level});
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [NK-1:0] k);
      @(negedge clk);
      key_n = k;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      key_n = '0;
      wait_cycles(6);
      n_cmp++;
      if (key_level !== '0) begin
         n_bad++;
         $display("FAIL reset_level: actual %b required 0000", key_level);
      end
      n_cmp++;
      if (key_press !== '0) begin
         n_bad++;
         $display("FAIL reset_press: actual %b required 0000", key_press);
      end
      n_cmp++;
      if (key_release !== '0) begin
         n_bad++;
         $display("FAIL reset_release: actual %b required 0000", key_release);
      end
      drive('1);
      wait_cycles(2);
      @(negedge clk);
      reset = 1'b1;
      wait_cycles(10);
      n_cmp++;
      if (key_level !== '0) begin
         n_bad++;
         $display("FAIL reset_idle_level: actual %b required 0000", key_level);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL reset extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_clean_press();
      int c;
      drive(4'b1110);
      c = cyc;
      exp_q.push_back('{c + 7, 4'b0001, 4'b0000, 4'b0001});
      wait_cycles(5);
      n_cmp++;
      if (key_level[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL clean_early_level: actual %b required 0 at edge 6", key_level[0]);
      end
      wait_cycles(5);
      n_cmp++;
      if (key_level !== 4'b0001) begin
         n_bad++;
         $display("FAIL clean_level: actual %b required 0001", key_level);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL clean missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL clean pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL clean extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_release();
      int d;
      drive(4'b1111);
      drive(4'b1111);
      drive(4'b1110);
      wait_cycles(10);
      n_cmp++;
      if (key_level !== 4'b0001) begin
         n_bad++;
         $display("FAIL glitch_level: actual %b required 0001", key_level);
      end
      drive(4'b1111);
      d = cyc;
      exp_q.push_back('{d + 7, 4'b0000, 4'b0001, 4'b0000});
      wait_cycles(10);
      n_cmp++;
      if (key_level !== 4'b0000) begin
         n_bad++;
         $display("FAIL release_level: actual %b required 0000", key_level);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL release missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL release pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL release extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_bounce();
      int c;
      int d;
      // Bounce: 3 low, 1 high, then low and held.
      drive(4'b1110);
      drive(4'b1110);
      drive(4'b1110);
      drive(4'b1111);
      drive(4'b1110);
      c = cyc;
      exp_q.push_back('{c + 7, 4'b0001, 4'b0000, 4'b0001});
      wait_cycles(10);
      drive(4'b1111);
      d = cyc;
      exp_q.push_back('{d + 7, 4'b0000, 4'b0001, 4'b0000});
      wait_cycles(10);
      // Debounce boundary: 4 low cycles fall one short, 5 low cycles are accepted.
      drive(4'b1110);
      repeat (3) drive(4'b1110);
      drive(4'b1111);
      wait_cycles(10);
      drive(4'b1110);
      c = cyc;
      repeat (4) drive(4'b1110);
      drive(4'b1111);
      exp_q.push_back('{c + 7, 4'b0001, 4'b0000, 4'b0001});
      exp_q.push_back('{c + 12, 4'b0000, 4'b0001, 4'b0000});
      wait_cycles(12);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL bounce missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL bounce pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL bounce extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_reset_mid();
      int r;
      int d;
      drive(4'b1110);
      wait_cycles(4);
      reset = 1'b0;
      wait_cycles(3);
      n_cmp++;
      if ({key_level, key_press, key_release} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: actual l=%b p=%b r=%b required all 0", key_level, key_press, key_release);
      end
      @(negedge clk);
      reset = 1'b1;
      r = cyc;
      exp_q.push_back('{r + 7, 4'b0001, 4'b0000, 4'b0001});
      wait_cycles(10);
      drive(4'b1111);
      d = cyc;
      exp_q.push_back('{d + 7, 4'b0000, 4'b0001, 4'b0000});
      wait_cycles(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL midreset missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL midreset pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL midreset extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_simultaneous();
      int c;
      int d;
      drive(4'b0000);
      c = cyc;
      exp_q.push_back('{c + 7, 4'b1111, 4'b0000, 4'b1111});
      wait_cycles(9);
      // One-cycle glitch on key 1 while all are held.
      drive(4'b0010);
      drive(4'b0000);
      wait_cycles(8);
      drive(4'b1111);
      d = cyc;
      exp_q.push_back('{d + 7, 4'b0000, 4'b1111, 4'b0000});
      wait_cycles(10);
      // Staggered presses with key 1 bouncing alongside.
      drive(4'b1010);
      c = cyc;
      drive(4'b1000);
      drive(4'b0010);
      exp_q.push_back('{c + 7, 4'b0101, 4'b0000, 4'b0101});
      exp_q.push_back('{c + 9, 4'b1000, 4'b0000, 4'b1101});
      wait_cycles(10);
      n_cmp++;
      if (key_level !== 4'b1101) begin
         n_bad++;
         $display("FAIL stagger_level: actual %b required 1101", key_level);
      end
      drive(4'b1111);
      d = cyc;
      exp_q.push_back('{d + 7, 4'b0000, 4'b1101, 4'b0000});
      wait_cycles(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL simul missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL simul pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL simul extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   task automatic test_auto_repeat();
      int c;
      drive(4'b1110);
      c = cyc;
      exp_q.push_back('{c + 7,  4'b0001, 4'b0000, 4'b0001});
      exp_q.push_back('{c + 17, 4'b0001, 4'b0000, 4'b0001});
      exp_q.push_back('{c + 20, 4'b0001, 4'b0000, 4'b0001});
      exp_q.push_back('{c + 23, 4'b0001, 4'b0000, 4'b0001});
      wait_cycles(20);
      drive(4'b1111);
      exp_q.push_back('{c + 28, 4'b0000, 4'b0001, 4'b0000});
      wait_cycles(15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_bad++;
            $display("FAIL repeat missing pulse: actual none, required cyc=%0d p=%b r=%b l=%b", e.c, e.p, e.r, e.l);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_bad++;
               $display("FAIL repeat pulse: actual cyc=%0d p=%b r=%b l=%b, required cyc=%0d p=%b r=%b l=%b", o.c, o.p, o.r, o.l, e.c, e.p, e.r, e.l);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL repeat extra pulse: actual cyc=%0d p=%b r=%b, required none", o.c, o.p, o.r);
      end
   endtask

   initial begin
      reset = 1'b0;
      key_n = '1;
      test_reset();
`ifdef KEY_AUTO_REPEAT_EN
      test_auto_repeat();
`else
      test_clean_press();
      test_release();
      test_bounce();
      test_reset_mid();
      test_simultaneous();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
